// File: rtl/hydra_pkg.sv
// Shared definitions for the hydra read-side packet sink: header layout, codes, FSM states.
// Pure definitions; no timing or flow-control behaviour lives here.
package hydra_pkg;

  localparam int LEN_MSB  = 15;
  localparam int LEN_LSB  = 7;
  localparam int PRIO_MSB = 6;
  localparam int PRIO_LSB = 4;
  localparam int DEST_MSB = 3;
  localparam int DEST_LSB = 0;

  localparam int LEN_W  = LEN_MSB - LEN_LSB + 1;
  localparam int PRIO_W = PRIO_MSB - PRIO_LSB + 1;
  localparam int DEST_W = DEST_MSB - DEST_LSB + 1;
  localparam int BEAT_W = 9;

  typedef enum logic [2:0] {
    ERR_NONE    = 3'd0,
    ERR_DEST    = 3'd1,
    ERR_SHORT   = 3'd2,
    ERR_LONG    = 3'd3,
    ERR_TIMEOUT = 3'd4,
    ERR_SOP     = 3'd5
  } err_code_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT_SOP,
    S_WAIT_HDR,
    S_PAYLOAD,
    S_DONE,
    S_GAP
  } state_e;

  // 16-bit words carry two bytes, so an odd byte length rounds up one beat.
  function automatic logic [BEAT_W-1:0] beats_from_len(input logic [LEN_W-1:0] len);
    logic [LEN_W:0] sum;
    sum = {1'b0, len} + (LEN_W + 1)'(1);
    return sum[LEN_W:1];
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Width-parameterised up-counter that sticks at all-ones; clr wins over inc.
// Result visible one cycle after inc; no backpressure.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      q <= '0;
    end else if (inc && (q != {W{1'b1}})) begin
      q <= q + W'(1);
    end
  end

endmodule

// File: rtl/port_rx_sink.sv
// Egress packet sink: requests one packet per ready pulse, checks it against its header.
// pkt_done one cycle after rd_eop; next ready READY_GAP+2 cycles after rd_eop; never stalls the switch.
module port_rx_sink
  import hydra_pkg::*;
#(
  parameter logic [DEST_W-1:0] PORT_ID   = 4'd0,
  parameter int                READY_GAP = 4,
  parameter int                TIMEOUT   = 1023
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic               rd_sop,
  input  logic               rd_eop,
  input  logic               rd_vld,
  input  logic [15:0]        rd_data,
  output logic               ready,
  output logic               pkt_done,
  output logic [LEN_W-1:0]   pkt_len,
  output logic [PRIO_W-1:0]  pkt_prio,
  output logic [15:0]        pkt_xor,
  output logic               pkt_err,
  output logic [2:0]         err_code,
  output logic [15:0]        pkt_cnt,
  output logic [15:0]        err_cnt
);

  localparam int              TMO_W    = ($clog2(TIMEOUT + 1) > 10) ? $clog2(TIMEOUT + 1) : 10;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
  localparam logic [7:0]      GAP_LAST = 8'(READY_GAP - 1);
  localparam bit              GAP_NONE = (READY_GAP == 0);

  state_e              state, state_nxt;
  logic [TMO_W-1:0]    tmo_cnt;
  logic [7:0]          gap_cnt;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [PRIO_W-1:0]   prio_q, prio_d;
  logic [15:0]         xor_q, xor_d;
  err_code_e           code_q, code_d;
  logic [BEAT_W-1:0]   beat_q, beat_nxt, beats_now, exp_beats;
  logic                beat_clr, beat_inc, hdr_take, pkt_end, restart, timeout_hit;
  logic                fin, done_q;

  assign beat_nxt = (beat_q == '1) ? beat_q : beat_q + BEAT_W'(1);
  // A mid-packet sop reports the abandoned packet while parsing of the new one begins.
  assign fin      = pkt_end | restart | timeout_hit;

  always_comb begin
    len_d       = len_q;
    prio_d      = prio_q;
    xor_d       = xor_q;
    code_d      = code_q;
    hdr_take    = 1'b0;
    pkt_end     = 1'b0;
    restart     = 1'b0;
    timeout_hit = 1'b0;
    beat_clr    = 1'b0;
    beat_inc    = 1'b0;
    exp_beats   = beats_from_len(len_q);
    beats_now   = beat_q;
    case (state)
      S_REQ: begin
        len_d    = '0;
        prio_d   = '0;
        xor_d    = '0;
        code_d   = ERR_NONE;
        beat_clr = 1'b1;
      end
      S_WAIT_SOP: begin
        if (!rd_sop && (tmo_cnt == TMO_LAST)) begin
          timeout_hit = 1'b1;
          code_d      = ERR_TIMEOUT;
        end
      end
      S_WAIT_HDR, S_PAYLOAD: begin
        if (rd_sop) begin
          restart = 1'b1;
          if (code_q == ERR_NONE) code_d = ERR_SOP;
        end else if (state == S_WAIT_HDR) begin
          if (rd_vld) begin
            hdr_take  = 1'b1;
            beat_clr  = 1'b1;
            len_d     = rd_data[LEN_MSB:LEN_LSB];
            prio_d    = rd_data[PRIO_MSB:PRIO_LSB];
            exp_beats = beats_from_len(rd_data[LEN_MSB:LEN_LSB]);
            beats_now = '0;
            if (rd_data[DEST_MSB:DEST_LSB] != PORT_ID) code_d = ERR_DEST;
          end
          if (rd_eop) begin
            pkt_end = 1'b1;
            if ((code_d == ERR_NONE) && (!rd_vld || (beats_now < exp_beats))) code_d = ERR_SHORT;
          end
        end else begin
          // The word on an eop beat is counted before the length check.
          if (rd_vld) begin
            beat_inc  = 1'b1;
            xor_d     = xor_q ^ rd_data;
            beats_now = beat_nxt;
            if ((code_d == ERR_NONE) && (beat_q >= exp_beats)) code_d = ERR_LONG;
          end
          if (rd_eop) begin
            pkt_end = 1'b1;
            if ((code_d == ERR_NONE) && (beats_now < exp_beats)) code_d = ERR_SHORT;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:     if (enable) state_nxt = S_REQ;
      S_REQ:      state_nxt = S_WAIT_SOP;
      S_WAIT_SOP: begin
        if (rd_sop)           state_nxt = S_WAIT_HDR;
        else if (timeout_hit) state_nxt = S_DONE;
      end
      S_WAIT_HDR: begin
        if (restart)       state_nxt = S_WAIT_HDR;
        else if (pkt_end)  state_nxt = S_DONE;
        else if (hdr_take) state_nxt = S_PAYLOAD;
      end
      S_PAYLOAD: begin
        if (restart)      state_nxt = S_WAIT_HDR;
        else if (pkt_end) state_nxt = S_DONE;
      end
      // The idle step is folded into the gap exit so ready lands READY_GAP+2 after eop.
      S_DONE: begin
        if (!GAP_NONE)   state_nxt = S_GAP;
        else if (enable) state_nxt = S_REQ;
        else             state_nxt = S_IDLE;
      end
      S_GAP:      if (gap_cnt == GAP_LAST) state_nxt = enable ? S_REQ : S_IDLE;
      default:    state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    ready    = (state == S_REQ);
    pkt_done = done_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt  <= '0;
      gap_cnt  <= '0;
      len_q    <= '0;
      prio_q   <= '0;
      xor_q    <= '0;
      code_q   <= ERR_NONE;
      done_q   <= 1'b0;
      pkt_len  <= '0;
      pkt_prio <= '0;
      pkt_xor  <= '0;
      pkt_err  <= 1'b0;
      err_code <= '0;
    end else begin
      tmo_cnt <= (state == S_WAIT_SOP) ? tmo_cnt + TMO_W'(1) : '0;
      gap_cnt <= (state == S_GAP) ? gap_cnt + 8'd1 : '0;
      done_q  <= fin;
      if (restart) begin
        xor_q  <= '0;
        code_q <= ERR_NONE;
      end else begin
        len_q  <= len_d;
        prio_q <= prio_d;
        xor_q  <= xor_d;
        code_q <= code_d;
      end
      if (fin) begin
        pkt_len  <= len_d;
        pkt_prio <= prio_d;
        pkt_xor  <= xor_d;
        pkt_err  <= (code_d != ERR_NONE);
        err_code <= code_d;
      end
    end
  end

  // Counters step on the same edge as the result fields, so they agree during pkt_done.
  sat_counter #(.W(16)) u_pkt_cnt (
    .clk (clk),
    .rst (rst),
    .clr (1'b0),
    .inc (fin && (code_d == ERR_NONE)),
    .q   (pkt_cnt)
  );

  sat_counter #(.W(16)) u_err_cnt (
    .clk (clk),
    .rst (rst),
    .clr (1'b0),
    .inc (fin && (code_d != ERR_NONE)),
    .q   (err_cnt)
  );

  sat_counter #(.W(BEAT_W)) u_beat_cnt (
    .clk (clk),
    .rst (rst),
    .clr (beat_clr | restart),
    .inc (beat_inc),
    .q   (beat_q)
  );

endmodule

// File: tb/tb_port_rx_sink.sv
// Directed bench for port_rx_sink: driver queues hand-computed results, monitor checks each pkt_done.
module tb_port_rx_sink;

  logic        clk = 1'b0;
  logic        rst, enable, rd_sop, rd_eop, rd_vld;
  logic [15:0] rd_data;
  logic        ready, pkt_done, pkt_err;
  logic [8:0]  pkt_len;
  logic [2:0]  pkt_prio, err_code;
  logic [15:0] pkt_xor, pkt_cnt, err_cnt;

  int cyc    = 0;
  int checks = 0;
  int errors = 0;

  typedef struct {
    int cyc;
    int len;
    int prio;
    int xr;
    int code;
    int pc;
    int ec;
  } exp_t;

  exp_t sb[$];

  port_rx_sink #(.PORT_ID(4'd3), .READY_GAP(4), .TIMEOUT(20)) dut (
    .clk      (clk),
    .rst      (rst),
    .enable   (enable),
    .rd_sop   (rd_sop),
    .rd_eop   (rd_eop),
    .rd_vld   (rd_vld),
    .rd_data  (rd_data),
    .ready    (ready),
    .pkt_done (pkt_done),
    .pkt_len  (pkt_len),
    .pkt_prio (pkt_prio),
    .pkt_xor  (pkt_xor),
    .pkt_err  (pkt_err),
    .err_code (err_code),
    .pkt_cnt  (pkt_cnt),
    .err_cnt  (err_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d", name, act, act, exp, exp, cyc);
    end
  endtask

  task automatic expect_done(input int dc, input int len, input int prio, input int xr,
                             input int code, input int pc, input int ec);
    exp_t e;
    e.cyc = dc; e.len = len; e.prio = prio; e.xr = xr; e.code = code; e.pc = pc; e.ec = ec;
    sb.push_back(e);
  endtask

  task automatic step(input logic s, input logic v, input logic e, input logic [15:0] d);
    @(posedge clk);
    #1;
    rd_sop = s; rd_vld = v; rd_eop = e; rd_data = d;
  endtask

  // Header beat, then n payload words base, base+1, ...; eop rides the last beat when asked.
  task automatic body(input logic [15:0] hdr, input int n, input logic [15:0] base, input bit eop_last);
    step(1'b0, 1'b1, (n == 0) && eop_last, hdr);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1, eop_last && (i == n - 1), base + 16'(i));
  endtask

  task automatic wait_ready(output int rc);
    int n;
    n = 0;
    @(negedge clk);
    while (ready !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("ready_pulse_seen", int'(ready), 1);
    rc = cyc;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_ready"},    int'(ready),    0);
    chk({tag, "_pkt_done"}, int'(pkt_done), 0);
    chk({tag, "_pkt_len"},  int'(pkt_len),  0);
    chk({tag, "_pkt_prio"}, int'(pkt_prio), 0);
    chk({tag, "_pkt_xor"},  int'(pkt_xor),  0);
    chk({tag, "_pkt_err"},  int'(pkt_err),  0);
    chk({tag, "_err_code"}, int'(err_code), 0);
    chk({tag, "_pkt_cnt"},  int'(pkt_cnt),  0);
    chk({tag, "_err_cnt"},  int'(err_cnt),  0);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (pkt_done === 1'b1) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: pkt_done at cycle %0d with nothing outstanding", cyc);
        end else begin
          e = sb.pop_front();
          chk("done_cycle", cyc, e.cyc);
          chk("pkt_len",  int'(pkt_len),  e.len);
          chk("pkt_prio", int'(pkt_prio), e.prio);
          chk("pkt_xor",  int'(pkt_xor),  e.xr);
          chk("pkt_err",  int'(pkt_err),  int'(e.code != 0));
          chk("err_code", int'(err_code), e.code);
          chk("pkt_cnt",  int'(pkt_cnt),  e.pc);
          chk("err_cnt",  int'(err_cnt),  e.ec);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int r, r2, eop_c, seen;
    rst = 1'b1; enable = 1'b0;
    rd_sop = 1'b0; rd_vld = 1'b0; rd_eop = 1'b0; rd_data = '0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    @(posedge clk); #1; rst = 1'b0; enable = 1'b1;

    // Good packet: L=34 (17 beats), prio 4, dest 3; XOR of 1..17 is 1.
    wait_ready(r);
    step(1'b1, 1'b0, 1'b0, '0);
    body(16'h1143, 17, 16'h0001, 1'b1);
    eop_c = cyc;
    expect_done(cyc + 1, 34, 4, 16'h0001, 0, 1, 0);
    step(1'b0, 1'b0, 1'b0, '0);
    wait_ready(r);
    chk("ready_after_pkt", r, eop_c + 6);

    // Dest mismatch: L=32, prio 1, dest 2, 16 beats; XOR 1..16 = 0x10.
    step(1'b1, 1'b0, 1'b0, '0);
    body(16'h1012, 16, 16'h0001, 1'b1);
    expect_done(cyc + 1, 32, 1, 16'h0010, 1, 1, 1);
    step(1'b0, 1'b0, 1'b0, '0);

    // Short: L=31 (16 beats) ends after 14; XOR 1..14 = 0xF.
    wait_ready(r);
    step(1'b1, 1'b0, 1'b0, '0);
    body(16'h0FA3, 14, 16'h0001, 1'b1);
    expect_done(cyc + 1, 31, 2, 16'h000F, 2, 1, 2);
    step(1'b0, 1'b0, 1'b0, '0);

    // Long: same header, 18 beats; XOR 1..18 = 0x13.
    wait_ready(r);
    step(1'b1, 1'b0, 1'b0, '0);
    body(16'h0FA3, 18, 16'h0001, 1'b1);
    expect_done(cyc + 1, 31, 2, 16'h0013, 3, 1, 3);
    step(1'b0, 1'b0, 1'b0, '0);

    // Timeout: no sop after ready.
    wait_ready(r);
    expect_done(r + 21, 0, 0, 0, 4, 1, 4);
    @(negedge clk);
    chk("ready_width", int'(ready), 0);
    wait_ready(r2);
    chk("ready_after_timeout", r2, r + 26);

    // Mid-packet sop after header + 3 beats (0x10^0x11^0x12 = 0x13), then a clean packet.
    step(1'b1, 1'b0, 1'b0, '0);
    body(16'h0553, 3, 16'h0010, 1'b0);
    step(1'b1, 1'b0, 1'b0, '0);
    expect_done(cyc + 1, 10, 5, 16'h0013, 5, 1, 5);
    body(16'h0553, 5, 16'h0001, 1'b1);
    expect_done(cyc + 1, 10, 5, 16'h0001, 0, 2, 5);
    step(1'b0, 1'b0, 1'b0, '0);

    // eop before any header beat.
    wait_ready(r);
    step(1'b1, 1'b0, 1'b0, '0);
    step(1'b0, 1'b0, 1'b1, '0);
    expect_done(cyc + 1, 0, 0, 0, 2, 2, 6);
    step(1'b0, 1'b0, 1'b0, '0);

    // L=0 with eop on the header; enable dropped mid-packet holds off the next request.
    wait_ready(r);
    enable = 1'b0;
    step(1'b1, 1'b0, 1'b0, '0);
    body(16'h0073, 0, 16'h0000, 1'b1);
    expect_done(cyc + 1, 0, 7, 0, 0, 3, 6);
    step(1'b0, 1'b0, 1'b0, '0);
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (ready === 1'b1) seen++;
    end
    chk("ready_withheld", seen, 0);
    enable = 1'b1;

    // Reset in PAYLOAD.
    wait_ready(r);
    step(1'b1, 1'b0, 1'b0, '0);
    body(16'h1143, 2, 16'h0001, 1'b0);
    @(posedge clk); #1;
    rd_vld = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_all_zero("post_rst");
    @(negedge clk);
    chk("ready_after_rst", int'(ready), 1);

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
